// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage core.
// Decides, every cycle, which pipeline registers advance, which load a
// bubble, and holds the pipe while RAM accesses or UART handshakes complete.
module pipeline_hazard_controller #(
    parameter int RAM_LATENCY = 2,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        id_rs1_address,
    input  logic [4:0]        id_rs2_address,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [4:0]        id_ex_rd_address,
    input  logic              id_ex_ram_read,
    input  logic              id_ex_stdin_read_enable,
    input  logic [1:0]        ex_mem_next_pc_src,
    input  logic              ex_mem_ram_read,
    input  logic              ex_mem_ram_write_enable,
    input  logic              ex_mem_stdin_read_enable,
    input  logic              ex_mem_stdout_write_enable,
    input  logic              stdin_valid,
    input  logic              stdout_ready,
    output logic              pc_write_enable,
    output logic              if_id_write_enable,
    output logic              id_ex_write_enable,
    output logic              ex_mem_write_enable,
    output logic              mem_wb_write_enable,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              stdin_ready,
    output logic              stdout_valid,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        IN_WAIT  = 2'd2,
        OUT_WAIT = 2'd3
    } state_t;

    // A single-cycle RAM never needs to hold the pipe.
    localparam bit         MEM_STALL = (RAM_LATENCY > 1);
    // The RUN cycle that detects the access is the first frozen cycle,
    // so the wait state only has to cover the remaining RAM_LATENCY-2.
    localparam logic [3:0] CNT_INIT  = (RAM_LATENCY > 1) ? 4'(RAM_LATENCY - 2) : 4'd0;

    // Control bundle: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    localparam logic [6:0] CTL_FREEZE   = 7'b00000_00;
    localparam logic [6:0] CTL_ADVANCE  = 7'b11111_00;
    localparam logic [6:0] CTL_REDIRECT = 7'b11111_11;
    localparam logic [6:0] CTL_BUBBLE   = 7'b00111_01;

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [6:0] ctl;
    logic       load_use;
    logic       redirect;
    logic       mem_access;

    // Normal advance: redirect beats load-use, load-use inserts one bubble
    // into ID/EX while PC and IF/ID hold the dependent instruction.
    function automatic logic [6:0] advance_ctl(input logic redir, input logic hazard);
        logic [6:0] result;
        result = CTL_ADVANCE;
        if (redir) begin
            result = CTL_REDIRECT;
        end else if (hazard) begin
            result = CTL_BUBBLE;
        end
        return result;
    endfunction

    assign redirect   = (ex_mem_next_pc_src != 2'd0);
    assign mem_access = ex_mem_ram_read | ex_mem_ram_write_enable;
    // x0 is hardwired to zero, so a write to it can never create a dependency.
    assign load_use   = (id_ex_ram_read | id_ex_stdin_read_enable)
                      && (id_ex_rd_address != 5'd0)
                      && ((id_rs1_used && (id_rs1_address == id_ex_rd_address))
                       || (id_rs2_used && (id_rs2_address == id_ex_rd_address)));

    assign {pc_write_enable, if_id_write_enable, id_ex_write_enable,
            ex_mem_write_enable, mem_wb_write_enable, if_id_flush, id_ex_flush} = ctl;

    // Next-state and output decode; memory-side holds mask redirect and load-use.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        ctl          = CTL_FREEZE;
        stdin_ready  = 1'b0;
        stdout_valid = 1'b0;
        case (state)
            RUN: begin
                if (MEM_STALL && mem_access) begin
                    cnt_next   = CNT_INIT;
                    state_next = MEM_WAIT;
                end else if (ex_mem_stdin_read_enable) begin
                    stdin_ready = stdin_valid;
                    if (stdin_valid) begin
                        ctl = advance_ctl(redirect, load_use);
                    end else begin
                        state_next = IN_WAIT;
                    end
                end else if (ex_mem_stdout_write_enable) begin
                    stdout_valid = 1'b1;
                    if (stdout_ready) begin
                        ctl = advance_ctl(redirect, load_use);
                    end else begin
                        state_next = OUT_WAIT;
                    end
                end else begin
                    ctl = advance_ctl(redirect, load_use);
                end
            end
            MEM_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    ctl        = advance_ctl(redirect, load_use);
                    state_next = RUN;
                end
            end
            IN_WAIT: begin
                stdin_ready = stdin_valid;
                if (stdin_valid) begin
                    ctl        = advance_ctl(redirect, load_use);
                    state_next = RUN;
                end
            end
            OUT_WAIT: begin
                stdout_valid = 1'b1;
                if (stdout_ready) begin
                    ctl        = advance_ctl(redirect, load_use);
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
        if (!reset_n) begin
            ctl          = CTL_FREEZE;
            stdin_ready  = 1'b0;
            stdout_valid = 1'b0;
        end
    end

    // State and wait counter; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Performance counter of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (!pc_write_enable) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with an instruction-age
// reference model checked every cycle plus hand-computed per-cycle values.
module tb_pipeline_hazard_controller;

    localparam int RAM_LATENCY = 3;
    localparam int PERF_W      = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [4:0]        id_rs1_address, id_rs2_address, id_ex_rd_address;
    logic              id_rs1_used, id_rs2_used;
    logic              id_ex_ram_read, id_ex_stdin_read_enable;
    logic [1:0]        ex_mem_next_pc_src;
    logic              ex_mem_ram_read, ex_mem_ram_write_enable;
    logic              ex_mem_stdin_read_enable, ex_mem_stdout_write_enable;
    logic              stdin_valid, stdout_ready;
    logic              pc_write_enable, if_id_write_enable, id_ex_write_enable;
    logic              ex_mem_write_enable, mem_wb_write_enable;
    logic              if_id_flush, id_ex_flush, stdin_ready, stdout_valid;
    logic [PERF_W-1:0] stall_cycles;
    logic [6:0]        ctl_act;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_controller #(.RAM_LATENCY(RAM_LATENCY), .PERF_W(PERF_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_ex_rd_address(id_ex_rd_address), .id_ex_ram_read(id_ex_ram_read),
        .id_ex_stdin_read_enable(id_ex_stdin_read_enable),
        .ex_mem_next_pc_src(ex_mem_next_pc_src), .ex_mem_ram_read(ex_mem_ram_read),
        .ex_mem_ram_write_enable(ex_mem_ram_write_enable),
        .ex_mem_stdin_read_enable(ex_mem_stdin_read_enable),
        .ex_mem_stdout_write_enable(ex_mem_stdout_write_enable),
        .stdin_valid(stdin_valid), .stdout_ready(stdout_ready),
        .pc_write_enable(pc_write_enable), .if_id_write_enable(if_id_write_enable),
        .id_ex_write_enable(id_ex_write_enable), .ex_mem_write_enable(ex_mem_write_enable),
        .mem_wb_write_enable(mem_wb_write_enable), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .stdin_ready(stdin_ready), .stdout_valid(stdout_valid),
        .stall_cycles(stall_cycles)
    );

    assign ctl_act = {pc_write_enable, if_id_write_enable, id_ex_write_enable,
                      ex_mem_write_enable, mem_wb_write_enable, if_id_flush, id_ex_flush};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an instruction in EX/MEM doing a RAM access must have
    // spent RAM_LATENCY cycles there before it leaves; UART ops leave on handshake.
    int         m_age   = 0;
    int         m_stall = 0;
    logic [6:0] e_ctl;
    logic       e_in_rdy, e_out_vld;

    initial begin
        logic io_block;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_ctl     = 7'b0;
            e_in_rdy  = 1'b0;
            e_out_vld = 1'b0;
            if (reset_n) begin
                if ((ex_mem_ram_read || ex_mem_ram_write_enable) && (m_age < RAM_LATENCY - 1)) begin
                    e_ctl = 7'b0;
                end else begin
                    io_block = 1'b0;
                    if (ex_mem_stdin_read_enable) begin
                        e_in_rdy = stdin_valid;
                        io_block = !stdin_valid;
                    end else if (ex_mem_stdout_write_enable) begin
                        e_out_vld = 1'b1;
                        io_block  = !stdout_ready;
                    end
                    if (!io_block) begin
                        if (ex_mem_next_pc_src != 0) begin
                            e_ctl = 7'b1111111;
                        end else if ((id_ex_ram_read || id_ex_stdin_read_enable) && id_ex_rd_address != 0 &&
                                     ((id_rs1_used && id_rs1_address == id_ex_rd_address) ||
                                      (id_rs2_used && id_rs2_address == id_ex_rd_address))) begin
                            e_ctl = 7'b0011101;
                        end else begin
                            e_ctl = 7'b1111100;
                        end
                    end
                end
            end
            check("model_ctl", 64'(ctl_act), 64'(e_ctl));
            check("model_stdin_ready", 64'(stdin_ready), 64'(e_in_rdy));
            check("model_stdout_valid", 64'(stdout_valid), 64'(e_out_vld));
            check("model_stall_cycles", 64'(stall_cycles), 64'(m_stall));
            @(posedge clk);
            if (!reset_n) begin
                m_age   = 0;
                m_stall = 0;
            end else begin
                if (!e_ctl[6]) m_stall++;
                if (e_ctl[3]) m_age = 0; else m_age++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        id_rs1_address = 0; id_rs2_address = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_ex_rd_address = 0; id_ex_ram_read = 0; id_ex_stdin_read_enable = 0;
        ex_mem_next_pc_src = 0; ex_mem_ram_read = 0; ex_mem_ram_write_enable = 0;
        ex_mem_stdin_read_enable = 0; ex_mem_stdout_write_enable = 0;
        stdin_valid = 0; stdout_ready = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input string name, input logic [6:0] ctl,
                                input logic in_rdy, input logic out_vld, input int stall);
        @(negedge clk);
        #1;
        check({name, "_ctl"}, 64'(ctl_act), 64'(ctl));
        check({name, "_stdin_ready"}, 64'(stdin_ready), 64'(in_rdy));
        check({name, "_stdout_valid"}, 64'(stdout_valid), 64'(out_vld));
        check({name, "_stall"}, 64'(stall_cycles), 64'(stall));
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        id_ex_ram_read = 1; id_ex_rd_address = rd; id_rs2_used = 1; id_rs2_address = rd;
    endtask

    initial begin
        clear_inputs();
        reset_n = 0;
        // Reset: outputs forced low even with requests present.
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            ex_mem_stdout_write_enable = 1; ex_mem_next_pc_src = 2'd1; stdin_valid = 1;
            expect_cycle("reset", 7'b0, 0, 0, 0);
        end
        next_cycle(); reset_n = 1; clear_inputs();
        expect_cycle("idle", 7'b1111100, 0, 0, 0);

        // Load-use on rs2: exactly one bubble.
        next_cycle(); set_load_use(5'd5);
        expect_cycle("loaduse", 7'b0011101, 0, 0, 0);
        next_cycle(); clear_inputs();
        expect_cycle("loaduse_after", 7'b1111100, 0, 0, 1);

        // Store with RAM_LATENCY=3: two frozen cycles, advance on the third.
        next_cycle(); ex_mem_ram_write_enable = 1;
        expect_cycle("store_c1", 7'b0, 0, 0, 1);
        next_cycle();
        expect_cycle("store_c2", 7'b0, 0, 0, 2);
        next_cycle();
        expect_cycle("store_c3", 7'b1111100, 0, 0, 3);
        next_cycle(); clear_inputs();
        expect_cycle("store_after", 7'b1111100, 0, 0, 3);

        // Redirect coincident with load-use: flush both, no stall.
        next_cycle(); ex_mem_next_pc_src = 2'd2; set_load_use(5'd5);
        expect_cycle("redirect", 7'b1111111, 0, 0, 3);

        // stdin read, byte arrives after four cycles.
        next_cycle(); clear_inputs(); ex_mem_stdin_read_enable = 1;
        expect_cycle("stdin_w0", 7'b0, 0, 0, 3);
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            expect_cycle("stdin_wait", 7'b0, 0, 0, 3 + i);
        end
        next_cycle(); stdin_valid = 1;
        expect_cycle("stdin_go", 7'b1111100, 1, 0, 7);
        next_cycle(); ex_mem_stdin_read_enable = 0;
        expect_cycle("stdin_idle", 7'b1111100, 0, 0, 7);

        // stdout write held two cycles; a load-use arriving during the wait
        // bubbles only once the write is released.
        next_cycle(); clear_inputs(); ex_mem_stdout_write_enable = 1;
        expect_cycle("stdout_w0", 7'b0, 0, 1, 7);
        next_cycle(); set_load_use(5'd9);
        expect_cycle("stdout_w1", 7'b0, 0, 1, 8);
        next_cycle(); stdout_ready = 1;
        expect_cycle("stdout_go", 7'b0011101, 0, 1, 9);
        next_cycle(); clear_inputs();
        expect_cycle("stdout_after", 7'b1111100, 0, 0, 10);

        // stdin-use hazard on rs1.
        next_cycle(); id_ex_stdin_read_enable = 1; id_ex_rd_address = 5'd7;
        id_rs1_used = 1; id_rs1_address = 5'd7;
        expect_cycle("stdin_use", 7'b0011101, 0, 0, 10);
        // rd=x0 never hazards.
        next_cycle(); clear_inputs(); id_ex_ram_read = 1; id_rs1_used = 1; id_rs2_used = 1;
        expect_cycle("rd_x0", 7'b1111100, 0, 0, 11);
        // Matching register that the ID instruction does not read.
        next_cycle(); clear_inputs(); id_ex_ram_read = 1; id_ex_rd_address = 5'd9;
        id_rs1_address = 5'd9;
        expect_cycle("unused_rs", 7'b1111100, 0, 0, 11);

        // Reset in the middle of a RAM wait abandons the access.
        next_cycle(); clear_inputs(); ex_mem_ram_read = 1;
        expect_cycle("rst_mem_c1", 7'b0, 0, 0, 11);
        next_cycle(); reset_n = 0;
        expect_cycle("rst_mem_c2", 7'b0, 0, 0, 12);
        next_cycle(); reset_n = 1; clear_inputs();
        expect_cycle("rst_mem_after", 7'b1111100, 0, 0, 0);
        next_cycle(); ex_mem_ram_read = 1;
        expect_cycle("reload_c1", 7'b0, 0, 0, 0);
        next_cycle();
        expect_cycle("reload_c2", 7'b0, 0, 0, 1);
        next_cycle();
        expect_cycle("reload_c3", 7'b1111100, 0, 0, 2);
        next_cycle(); clear_inputs();
        expect_cycle("final", 7'b1111100, 0, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
